// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/control/result bundle for mul_div_unit; abort signal exists only with MD_ABORT_EN
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] md_control;
  logic start;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MD_ABORT_EN
  logic abort;
  modport master (output a, b, md_control, start, abort, input busy, done, hi, lo);
  modport slave (input a, b, md_control, start, abort, output busy, done, hi, lo);
`else
  modport master (output a, b, md_control, start, input busy, done, hi, lo);
  modport slave (input a, b, md_control, start, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative mult/multu/div/divu with HI/LO and mthi/mtlo; MD_ABORT_EN adds an abort input
module mul_div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mul_div_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] m, acc_hi, acc_lo, hi, lo, mag_a, mag_b;
  logic [WIDTH:0] sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, div_zero, done, abort, launch, sa, sb;
`ifdef MD_ABORT_EN
  assign abort = md.abort;
`else
  assign abort = 1'b0;
`endif
  assign launch = state == IDLE && md.start && !md.md_control[2];
  assign sa = !md.md_control[0] && md.a[WIDTH-1];
  assign sb = !md.md_control[0] && md.b[WIDTH-1];
  // An unsigned WIDTH-bit magnitude already covers 2^(WIDTH-1), the most-negative case
  assign mag_a = sa ? -md.a : md.a;
  assign mag_b = sb ? -md.b : md.b;
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign diff = shifted - {1'b0, m};
  assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign md.busy = state != IDLE;
  assign md.done = done;
  assign md.hi = hi;
  assign md.lo = lo;
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // Next state: abort only matters once an operation is in flight, so start wins in IDLE
  always_comb begin
    state_next = state;
    if (abort && state != IDLE) state_next = IDLE;
    else if (launch) state_next = RUN;
    else if (state == RUN && count == CW'(WIDTH - 1)) state_next = FIX;
    else if (state == FIX) state_next = IDLE;
  end
  // Datapath: m holds multiplicand/divisor magnitude, acc_lo shifts multiplier/dividend, acc_hi accumulates
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      m <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_zero <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= state == FIX && !abort;
      if (launch) begin
        count <= '0;
        is_div <= md.md_control[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        div_zero <= md.md_control[1] && md.b == '0;
        m <= md.md_control[1] ? mag_b : mag_a;
        acc_lo <= md.md_control[1] ? mag_a : mag_b;
        acc_hi <= '0;
      end else if (state == IDLE && md.start && md.md_control == 3'b100) hi <= md.a;
      else if (state == IDLE && md.start && md.md_control == 3'b101) lo <= md.a;
      else if (state == RUN) begin
        count <= count + 1'b1;
        acc_hi <= is_div ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        acc_lo <= is_div ? {acc_lo[WIDTH-2:0], !diff[WIDTH]} : {sum[0], acc_lo[WIDTH-1:1]};
      end else if (state == FIX && !abort) begin
        hi <= is_div ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? (div_zero ? '1 : neg_q ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (abort cases when MD_ABORT_EN is defined)
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  mul_div_unit_if #(.WIDTH(32)) md();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y);
    md.md_control = ctl;
    md.a = x;
    md.b = y;
    md.start = 1'b1;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    md.a = $urandom;
    md.b = $urandom;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!md.done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    launch(ctl, x, y);
    wait_done(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_hilo"}, {md.hi, md.lo}, {exp_hi, exp_lo});
  endtask
  initial begin
    int cyc;
    int dones;
    logic [31:0] h0, l0;
    md.a = '0;
    md.b = '0;
    md.md_control = 3'b110;
    md.start = 1'b0;
`ifdef MD_ABORT_EN
    md.abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {md.busy, md.done, md.hi, md.lo}, 66'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    launch(3'b000, 32'hFFFF_FFFD, 32'd5);
    for (int c = 1; c <= 34; c++) begin
      if (c == 1) check("mult_busy_c1", 64'(md.busy), 64'd1);
      if (c == 33) begin
        check("mult_busy_c33", 64'(md.busy), 64'd1);
        check("mult_done_c33", 64'(md.done), 64'd0);
        check("mult_hold_c33", {md.hi, md.lo}, 64'd0);
      end
      if (c == 34) begin
        check("mult_done_c34", 64'(md.done), 64'd1);
        check("mult_busy_c34", 64'(md.busy), 64'd0);
        check("mult_res", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      end
      if (c < 34) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    check("done_pulse", 64'(md.done), 64'd0);
    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_negb", 3'b000, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
    do_op("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    do_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_zero", 3'b010, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op("div_wrap", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    launch(3'b100, 32'hCAFE_BABE, 32'd0);
    check("mthi", {md.busy, md.done, md.hi, md.lo}, {2'b00, 32'hCAFE_BABE, 32'h8000_0000});
    launch(3'b101, 32'h1357_9BDF, 32'd0);
    check("mtlo", {md.busy, md.done, md.hi, md.lo}, {2'b00, 32'hCAFE_BABE, 32'h1357_9BDF});
    launch(3'b110, 32'hDEAD_BEEF, 32'd0);
    check("noop", {md.busy, md.hi, md.lo}, {1'b0, 32'hCAFE_BABE, 32'h1357_9BDF});
    launch(3'b011, 32'd100, 32'd7);
    dones = 0;
    for (int c = 1; c < 80; c++) begin
      if (md.done) dones++;
      md.start = c == 5 || c == 20;
      md.md_control = 3'b101;
      md.a = 32'd3;
      md.b = 32'd3;
      @(posedge clk);
      #1;
    end
    md.start = 1'b0;
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_res", {md.hi, md.lo}, {32'd2, 32'd14});
`ifdef MD_ABORT_EN
    launch(3'b000, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    md.abort = 1'b1;
    @(posedge clk);
    #1;
    md.abort = 1'b0;
    check("abort_busy", 64'(md.busy), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (md.done) dones++;
      @(posedge clk);
      #1;
    end
    check("abort_dones", 64'(dones), 64'd0);
    check("abort_hold", {md.hi, md.lo}, {32'd2, 32'd14});
`endif
    launch(3'b000, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst", {md.busy, md.done, md.hi, md.lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(cyc);
    check("rst_no_done", 64'(cyc), 64'd60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
